// File: rtl/wire_pipe_if.sv
// wire_pipe_if: handshake bundle for wire_pipe.
//   in_data/in_valid/in_ready     producer side (valid/ready)
//   out_data/out_valid/out_ready  consumer side (valid/ready)
//   occupancy                     number of valid stages
//   parity_err                    sticky parity error flag
// Modports: slave = the pipe itself, master = the environment driving it.
interface wire_pipe_if #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned OccW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [OccW-1:0]  occupancy;
    logic             parity_err;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, occupancy, parity_err
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, occupancy, parity_err
    );
endinterface

// File: rtl/wire_pipe.sv
// wire_pipe: WIDTH-bit value carried through DEPTH register stages with
// valid/ready flow control. A stage may load whenever it, or any stage
// downstream of it, is empty, so bubbles collapse toward the output while
// the consumer stalls. Order is strictly FIFO.
// Ports:
//   clk   single clock, all state on posedge
//   rst   synchronous active-high reset; flushes every in-flight item
//   pipe  wire_pipe_if.slave (in/out handshakes, occupancy, parity_err)
// Optional feature macro: WIRE_PIPE_PARITY_EN adds a per-stage even-parity
// bit checked on every transfer out; parity_err is sticky until rst.
// Without the macro parity_err is tied to 0.
module wire_pipe #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 4
) (
    input logic        clk,
    input logic        rst,
    wire_pipe_if.slave pipe
);
    localparam int unsigned OccW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0]            rdy;
    logic [OccW-1:0]             occ_q, occ_d;
    logic                        in_ready;
    logic                        xfer_in, xfer_out;

    // rdy[i] = !v[i] | rdy[i+1] unrolled: stage i may advance when the
    // consumer is ready or any stage from i to the output holds a bubble.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rdy[i] = pipe.out_ready;
            for (int j = i; j < DEPTH; j++) begin
                if (!valid_q[j]) begin
                    rdy[i] = 1'b1;
                end
            end
        end
    end

    assign in_ready = rdy[0] & ~rst;
    assign xfer_in  = pipe.in_valid & in_ready;
    assign xfer_out = valid_q[DEPTH-1] & pipe.out_ready;

    // Data only moves with a valid item, so an emptied output stage keeps
    // showing its last value.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (rdy[0]) begin
            valid_d[0] = pipe.in_valid;
            if (pipe.in_valid) begin
                data_d[0] = pipe.in_data;
            end
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (rdy[i]) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_d[i] = data_q[i-1];
                end
            end
        end
    end

    always_comb begin
        unique case ({xfer_in, xfer_out})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    assign pipe.in_ready  = in_ready;
    assign pipe.out_data  = data_q[DEPTH-1];
    assign pipe.out_valid = valid_q[DEPTH-1];
    assign pipe.occupancy = occ_q;

`ifdef WIRE_PIPE_PARITY_EN
    logic [DEPTH-1:0] par_q, par_d;
    logic             perr_q, perr_d;

    // Parity bits travel in lockstep with the data they were computed from.
    always_comb begin
        par_d = par_q;
        if (rdy[0] && pipe.in_valid) begin
            par_d[0] = ^pipe.in_data;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (rdy[i] && valid_q[i-1]) begin
                par_d[i] = par_q[i-1];
            end
        end
        perr_d = perr_q | (xfer_out & ((^data_q[DEPTH-1]) != par_q[DEPTH-1]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q  <= '0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end

    assign pipe.parity_err = perr_q;
`else
    assign pipe.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_wire_pipe.sv
module tb_wire_pipe;
    localparam int unsigned WIDTH = 3;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wire_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ifc ();

    wire_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .pipe (ifc.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every output transfer must match the oldest
    // expected item.
    task automatic monitor();
        logic [WIDTH-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && ifc.out_valid && ifc.out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0d required none", ifc.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(ifc.out_data), 32'(e));
                end
            end
        end
    endtask

    // Offer one item; the expected output is queued once it is accepted.
    task automatic send(input logic [WIDTH-1:0] d);
        bit done = 0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (ifc.in_ready) begin
                exp_q.push_back(d);
                done = 1;
            end
            tick();
        end
        ifc.in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
`ifdef WIRE_PIPE_PARITY_EN
        logic [DEPTH-1:0][WIDTH-1:0] tmp;
`endif
        ifc.in_valid  = 1'b1;
        ifc.in_data   = 3'b100;
        ifc.out_ready = 1'b0;
        fork
            monitor();
        join_none

        // 1: reset holds in_ready low and ignores the offered item
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            check("rst_in_ready", 32'(ifc.in_ready), 32'd0);
            check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
            check("rst_occupancy", 32'(ifc.occupancy), 32'd0);
            check("rst_parity_err", 32'(ifc.parity_err), 32'd0);
        end
        tick();
        rst          = 1'b0;
        ifc.in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(ifc.in_ready), 32'd1);
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            check("post_rst_no_output", 32'(ifc.out_valid), 32'd0);
        end

        // 2: fill latency of DEPTH cycles, back-to-back items
        tick();
        ifc.in_valid = 1'b1;
        ifc.in_data  = 3'b100;
        @(negedge clk);
        check("lat_accept0", 32'(ifc.in_ready), 32'd1);
        exp_q.push_back(3'b100);
        tick();
        ifc.in_data = 3'b011;
        @(negedge clk);
        check("lat_accept1", 32'(ifc.in_ready), 32'd1);
        exp_q.push_back(3'b011);
        tick();
        ifc.in_valid = 1'b0;
        @(negedge clk);
        check("lat_k1_valid", 32'(ifc.out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("lat_k2_valid", 32'(ifc.out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("lat_k3_valid", 32'(ifc.out_valid), 32'd1);
        check("lat_k3_data", 32'(ifc.out_data), 32'd4);
        tick();
        @(negedge clk);
        check("lat_k4_valid", 32'(ifc.out_valid), 32'd1);
        check("lat_k4_data", 32'(ifc.out_data), 32'd3);
        tick();
        @(negedge clk);
        check("lat_k5_valid", 32'(ifc.out_valid), 32'd0);
        check("lat_occ_empty", 32'(ifc.occupancy), 32'd0);

        // 3: stall fills the pipe, then drains in order
        tick();
        ifc.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(WIDTH'(i));
        ifc.in_valid = 1'b1;
        ifc.in_data  = 3'd5;
        @(negedge clk);
        check("full_in_ready", 32'(ifc.in_ready), 32'd0);
        check("full_occupancy", 32'(ifc.occupancy), 32'd4);
        check("full_out_data", 32'(ifc.out_data), 32'd1);
        tick();
        @(negedge clk);
        check("full_hold_in_ready", 32'(ifc.in_ready), 32'd0);
        tick();
        ifc.out_ready = 1'b1;
        send(3'd5);
        send(3'd6);
        wait_empty();
        tick();
        @(negedge clk);
        check("drained_valid", 32'(ifc.out_valid), 32'd0);
        check("drained_occupancy", 32'(ifc.occupancy), 32'd0);

        // 4: full with out_ready=1 streams one in, one out per cycle
        tick();
        ifc.out_ready = 1'b0;
        send(3'd7);
        send(3'd0);
        send(3'd1);
        send(3'd2);
        ifc.out_ready = 1'b1;
        base = n_out;
        for (int i = 0; i < 6; i++) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = WIDTH'(i + 2);
            @(negedge clk);
            check("stream_in_ready", 32'(ifc.in_ready), 32'd1);
            check("stream_occupancy", 32'(ifc.occupancy), 32'd4);
            exp_q.push_back(WIDTH'(i + 2));
            tick();
        end
        ifc.in_valid = 1'b0;
        check("stream_out_count", 32'(n_out - base), 32'd6);
        wait_empty();

        // 5: reset mid-operation discards in-flight items
        tick();
        ifc.out_ready = 1'b0;
        send(3'd5);
        send(3'd6);
        send(3'd7);
        @(negedge clk);
        check("pre_flush_occupancy", 32'(ifc.occupancy), 32'd3);
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("flush_occupancy", 32'(ifc.occupancy), 32'd0);
        check("flush_out_valid", 32'(ifc.out_valid), 32'd0);
        check("flush_in_ready", 32'(ifc.in_ready), 32'd1);
        base = n_out;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("flush_no_output", 32'(n_out - base), 32'd0);

`ifdef WIRE_PIPE_PARITY_EN
        // 6: corrupt stage 2 in flight; error flags after the transfer out
        send(3'b100);
        tick();
        tick();
        tmp = dut.data_q;
        check("par_stage2_data", 32'(tmp[2]), 32'd4);
        tmp[2][0] = ~tmp[2][0];
        force dut.data_q = tmp;
        #1;
        release dut.data_q;
        exp_q[exp_q.size() - 1] = 3'b101;
        tick();
        @(negedge clk);
        check("par_before_xfer", 32'(ifc.parity_err), 32'd0);
        check("par_out_valid", 32'(ifc.out_valid), 32'd1);
        tick();
        @(negedge clk);
        check("par_err_set", 32'(ifc.parity_err), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        @(negedge clk);
        check("par_err_sticky", 32'(ifc.parity_err), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("par_err_cleared", 32'(ifc.parity_err), 32'd0);
`else
        check("parity_err_tied", 32'(ifc.parity_err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
